// File: rtl/datapath_control_pipe.sv
// Elastic register pipeline carrying the decoded control->datapath bundle.
// Each stage holds one entry plus a valid bit. A combinational ready chain lets
// entries advance into bubbles. An incoming entry's sources are compared against
// the destinations of every valid in-flight writer to flag RAW hazards.
module datapath_control_pipe #(
    parameter int DEPTH        = 2,
    parameter int REG_ADDR_W   = 5,
    parameter int PAYLOAD_W    = 128,
    parameter int HAZARD_STALL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_regfile_we,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_regfile_we,
    output logic [PAYLOAD_W-1:0]  out_payload,
    output logic                  hazard,
    output logic [3:0]            occupancy
);
    // Packed entry layout, MSB first: {rs1, rs2, rd, regfile_we, payload}
    localparam int ENTRY_W  = 3 * REG_ADDR_W + 1 + PAYLOAD_W;
    localparam int WE_LSB   = PAYLOAD_W;
    localparam int RD_LSB   = PAYLOAD_W + 1;
    localparam int RS2_LSB  = RD_LSB + REG_ADDR_W;
    localparam int RS1_LSB  = RS2_LSB + REG_ADDR_W;
    localparam bit STALL_EN = (HAZARD_STALL != 0);

    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [ENTRY_W-1:0] data_q [DEPTH];
    logic [ENTRY_W-1:0] data_d [DEPTH];
    logic [3:0]         occupancy_q;
    logic [3:0]         occupancy_d;

    logic [DEPTH:0]     ready_s;
    logic [DEPTH-1:0]   up_valid_s;
    logic [ENTRY_W-1:0] up_data_s [DEPTH];
    logic [ENTRY_W-1:0] in_entry_s;
    logic [ENTRY_W-1:0] out_entry_s;
    logic               hazard_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               out_valid_s;
    logic               emit_s;

    // True when a stage entry is a real writer (we=1, rd!=0) targeting either source
    function automatic logic writer_hits(
        input logic [ENTRY_W-1:0]    entry,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        logic [REG_ADDR_W-1:0] rd;
        rd = entry[RD_LSB +: REG_ADDR_W];
        return entry[WE_LSB] & (rd != '0) & ((rd == rs1) | (rd == rs2));
    endfunction

    assign in_entry_s = {in_rs1, in_rs2, in_rd, in_regfile_we, in_payload};

    // Ready chain: a stage can take a new entry if it is empty or its successor can move
    always_comb begin
        ready_s        = '0;
        ready_s[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready_s[i] = ~valid_q[i] | ready_s[i+1];
        end
    end

    // Hazard: any valid in-flight writer (including one leaving this cycle) feeding a source
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard_s = hazard_s | (valid_q[i] & writer_hits(data_q[i], in_rs1, in_rs2));
        end
        hazard_s = hazard_s & in_valid;
    end

    // Handshake qualification; flush blocks both accept and emit
    always_comb begin
        in_ready_s  = ready_s[0] & ~flush & ~(STALL_EN & hazard_s);
        accept_s    = in_valid & in_ready_s;
        out_valid_s = valid_q[DEPTH-1] & ~flush;
        emit_s      = out_valid_s & out_ready;
        out_entry_s = out_valid_s ? data_q[DEPTH-1] : '0;
    end

    // Upstream source of each stage: the inputs for stage 0, the previous stage otherwise
    always_comb begin
        up_valid_s    = '0;
        up_valid_s[0] = accept_s;
        up_data_s[0]  = in_entry_s;
        for (int i = 1; i < DEPTH; i++) begin
            up_valid_s[i] = valid_q[i-1];
            up_data_s[i]  = data_q[i-1];
        end
    end

    // Next-state: stages advance when ready; flush clears valid bits but keeps data stale
    always_comb begin
        valid_d     = valid_q;
        occupancy_d = occupancy_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (ready_s[i]) begin
                valid_d[i] = up_valid_s[i];
            end else begin
                valid_d[i] = valid_q[i];
            end
            if (ready_s[i] && up_valid_s[i] && !flush) begin
                data_d[i] = up_data_s[i];
            end else begin
                data_d[i] = data_q[i];
            end
        end
        if (flush) begin
            occupancy_d = 4'd0;
        end else begin
            occupancy_d = occupancy_q + {3'b000, accept_s} - {3'b000, emit_s};
        end
    end

    // Stage and occupancy registers with asynchronous reset to an empty, zeroed pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            occupancy_q <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            occupancy_q <= occupancy_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign in_ready       = in_ready_s;
    assign hazard         = hazard_s;
    assign occupancy      = occupancy_q;
    assign out_valid      = out_valid_s;
    assign out_rs1        = out_entry_s[RS1_LSB +: REG_ADDR_W];
    assign out_rs2        = out_entry_s[RS2_LSB +: REG_ADDR_W];
    assign out_rd         = out_entry_s[RD_LSB +: REG_ADDR_W];
    assign out_regfile_we = out_entry_s[WE_LSB];
    assign out_payload    = out_entry_s[PAYLOAD_W-1:0];

endmodule

// File: tb/tb_datapath_control_pipe.sv
// Bench for datapath_control_pipe: several configurations share one stimulus
// stream; each has its own queue-based model. Directed sequences pin the model
// with literal expectations on the DEPTH=2 configurations.
module tb_datapath_control_pipe;
    localparam int NCFG = 5;
    localparam int RW   = 5;
    localparam int PW   = 128;

    function automatic int cfg_depth(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            3:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_stall(input int g);
        return (g == 4) ? 0 : 1;
    endfunction

    typedef struct packed {
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
        logic          we;
        logic [PW-1:0] pl;
        int            acc;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [RW-1:0] in_rs1;
    logic [RW-1:0] in_rs2;
    logic [RW-1:0] in_rd;
    logic          in_we;
    logic [PW-1:0] in_payload;

    logic          in_ready_w  [NCFG];
    logic          out_valid_w [NCFG];
    logic [RW-1:0] out_rs1_w   [NCFG];
    logic [RW-1:0] out_rs2_w   [NCFG];
    logic [RW-1:0] out_rd_w    [NCFG];
    logic          out_we_w    [NCFG];
    logic [PW-1:0] out_pl_w    [NCFG];
    logic          hazard_w    [NCFG];
    logic [3:0]    occ_w       [NCFG];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int D = cfg_depth(g);
        localparam int S = cfg_stall(g);

        ent_t q[$];
        int   c         = 0;
        int   last_emit = -100;
        logic acc_e     = 1'b0;
        logic emit_e    = 1'b0;

        datapath_control_pipe #(
            .DEPTH(D), .REG_ADDR_W(RW), .PAYLOAD_W(PW), .HAZARD_STALL(S)
        ) dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready_w[g]),
            .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
            .in_regfile_we(in_we), .in_payload(in_payload),
            .out_valid(out_valid_w[g]), .out_ready(out_ready),
            .out_rs1(out_rs1_w[g]), .out_rs2(out_rs2_w[g]), .out_rd(out_rd_w[g]),
            .out_regfile_we(out_we_w[g]), .out_payload(out_pl_w[g]),
            .hazard(hazard_w[g]), .occupancy(occ_w[g])
        );

        // Compare DUT against the model mid-cycle, once inputs have settled
        always @(negedge clk) begin : cmp
            logic hz;
            logic ir;
            logic ov;
            int   vis;
            logic [159:0] exp_out;
            if (rst) begin
                acc_e  <= 1'b0;
                emit_e <= 1'b0;
            end else begin
                hz = 1'b0;
                if (in_valid) begin
                    foreach (q[k]) begin
                        if (q[k].we && q[k].rd != 5'd0 &&
                            (q[k].rd == in_rs1 || q[k].rd == in_rs2)) hz = 1'b1;
                    end
                end
                ir = !flush && !(S != 0 && hz) && (q.size() < D || out_ready);
                ov = 1'b0;
                exp_out = '0;
                if (!flush && q.size() > 0) begin
                    vis = q[0].acc + D;
                    if (last_emit + 1 > vis) vis = last_emit + 1;
                    ov = (c >= vis);
                end
                if (ov) exp_out = {16'd0, q[0].rs1, q[0].rs2, q[0].rd, q[0].we, q[0].pl};
                check($sformatf("cfg%0d out_valid", g), {159'd0, out_valid_w[g]}, {159'd0, ov});
                check($sformatf("cfg%0d in_ready", g), {159'd0, in_ready_w[g]}, {159'd0, ir});
                check($sformatf("cfg%0d hazard", g), {159'd0, hazard_w[g]}, {159'd0, hz});
                check($sformatf("cfg%0d occupancy", g), {156'd0, occ_w[g]}, 160'(q.size()));
                check($sformatf("cfg%0d out_fields", g),
                      {16'd0, out_rs1_w[g], out_rs2_w[g], out_rd_w[g], out_we_w[g], out_pl_w[g]},
                      exp_out);
                acc_e  <= in_valid && ir;
                emit_e <= ov && out_ready;
            end
        end

        // Advance the model at each clock edge; reset empties it
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                last_emit <= -100;
            end else begin
                if (flush) begin
                    q.delete();
                end else begin
                    if (emit_e) begin
                        void'(q.pop_front());
                        last_emit <= c;
                    end
                    if (acc_e) q.push_back('{in_rs1, in_rs2, in_rd, in_we, in_payload, c});
                end
                c <= c + 1;
            end
        end
    end

    task automatic drive(input logic v, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                         input logic [RW-1:0] d, input logic w, input logic [PW-1:0] p,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid = v; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_we = w;
        in_payload = p; out_ready = ordy; flush = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 128'd0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_we = 1'b0; in_payload = 128'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming: pc 0,4,8 back to back, emitted two cycles later in order
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd0, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd4, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd8, 1'b1, 1'b0);
        @(negedge clk);
        check("t2 first valid", {159'd0, out_valid_w[0]}, 160'd1);
        check("t2 pc0", {32'd0, out_pl_w[0]}, 160'd0);
        idle(1);
        @(negedge clk);
        check("t2 pc4", {32'd0, out_pl_w[0]}, 160'd4);
        idle(1);
        @(negedge clk);
        check("t2 pc8", {32'd0, out_pl_w[0]}, 160'd8);
        idle(1);
        @(negedge clk);
        check("t2 drained", {159'd0, out_valid_w[0]}, 160'd0);
        idle(4);

        // Backpressure: pipe of two fills, third is refused until released
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd10, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd11, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd12, 1'b0, 1'b0);
        @(negedge clk);
        check("t3 full in_ready", {159'd0, in_ready_w[0]}, 160'd0);
        check("t3 full occupancy", {156'd0, occ_w[0]}, 160'd2);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd12, 1'b1, 1'b0);
        @(negedge clk);
        check("t3 release in_ready", {159'd0, in_ready_w[0]}, 160'd1);
        check("t3 out 10", {32'd0, out_pl_w[0]}, 160'd10);
        idle(1);
        @(negedge clk);
        check("t3 out 11", {32'd0, out_pl_w[0]}, 160'd11);
        idle(1);
        @(negedge clk);
        check("t3 out 12", {32'd0, out_pl_w[0]}, 160'd12);
        idle(6);

        // Hazard: in-flight writer rd=5, incoming rs1=5
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 128'd20, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 128'd21, 1'b0, 1'b0);
        @(negedge clk);
        check("t4 hazard stall", {159'd0, hazard_w[0]}, 160'd1);
        check("t4 in_ready stall", {159'd0, in_ready_w[0]}, 160'd0);
        check("t4 hazard report-only", {159'd0, hazard_w[4]}, 160'd1);
        check("t4 in_ready report-only", {159'd0, in_ready_w[4]}, 160'd1);
        idle(6);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 128'd22, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 128'd23, 1'b0, 1'b0);
        @(negedge clk);
        check("t4 rd0 hazard", {159'd0, hazard_w[0]}, 160'd0);
        check("t4 rd0 in_ready", {159'd0, in_ready_w[0]}, 160'd1);
        idle(6);
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 128'd24, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd5, 5'd1, 1'b0, 128'd25, 1'b0, 1'b0);
        @(negedge clk);
        check("t4 we0 hazard", {159'd0, hazard_w[0]}, 160'd0);
        check("t4 we0 in_ready", {159'd0, in_ready_w[0]}, 160'd1);
        idle(6);

        // Flush with two entries in flight and a new one offered
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd30, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd31, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd32, 1'b1, 1'b1);
        @(negedge clk);
        check("t5 flush out_valid", {159'd0, out_valid_w[0]}, 160'd0);
        check("t5 flush in_ready", {159'd0, in_ready_w[0]}, 160'd0);
        idle(1);
        @(negedge clk);
        check("t5 after occupancy", {156'd0, occ_w[0]}, 160'd0);
        check("t5 after out_valid", {159'd0, out_valid_w[0]}, 160'd0);
        idle(2);

        // Random valid/ready/flush traffic with a small register space to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
        end

        // Reset mid-stream: outputs go idle in the same cycle
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd40, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 128'd41, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t1 reset out_valid", {159'd0, out_valid_w[0]}, 160'd0);
        check("t1 reset occupancy", {156'd0, occ_w[0]}, 160'd0);
        check("t1 reset in_ready", {159'd0, in_ready_w[0]}, 160'd1);
        check("t1 reset out_payload", {32'd0, out_pl_w[0]}, 160'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        idle(8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
